stack_exec_unit: RTL

Datapath responder for control_module. Each cycle it consumes the decoded instruction fields (op_code, operands, operand/destination selects, push/pop) and executes them. It holds the register file, the operand LIFO stack and the ALU, and returns the registered zero_flag that control_module uses for branch decisions.

---
 rtl/exec_pkg.sv | 34 +++
 rtl/stack_exec_unit_lifo_stack.sv | 107 ++++++++++
 rtl/stack_exec_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_pkg
// Description : Shared widths, opcode enum and operand/destination select
//               encodings for stack_exec_unit.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

    localparam int OPCODE_WIDTH = 4;
    localparam int VALUE_WIDTH  = 8;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_MOV = 4'd6,
        OP_CMP = 4'd7
    } opcode_e;

    localparam logic [1:0] SEL_IMM   = 2'b00;
    localparam logic [1:0] SEL_REG   = 2'b01;
    localparam logic [1:0] SEL_TOS   = 2'b10;
    localparam logic [1:0] SEL_NOS   = 2'b11;

    localparam logic [1:0] DST_NONE  = 2'b00;
    localparam logic [1:0] DST_REG   = 2'b01;
    localparam logic [1:0] DST_STACK = 2'b10;

endpackage
`default_nettype wire

// File: rtl/stack_exec_unit_lifo_stack.sv
`default_nettype none
// ============================================================================
// Module      : lifo_stack
// Description : Operand LIFO with TOS/NOS read ports and pop-then-push update.
//               STACK_EXEC_GUARD_EN selects held pointer + sticky error on
//               overflow/underflow; otherwise the pointer wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module lifo_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_tos,
    output logic [WIDTH-1:0] o_nos,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_err
);
    import exec_pkg::*;

    localparam int              c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_DEPTH = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]   c_ONE   = (c_AW + 1)'(1);

    logic [c_AW:0]    r_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [c_AW:0]    w_ptr_mid;
    logic [c_AW:0]    w_ptr_next;
    logic [c_AW:0]    w_tos_ptr;
    logic [c_AW:0]    w_nos_ptr;
    logic             w_push_eff;
    logic             w_err_set;

    assign o_empty   = (r_ptr == '0);
    assign o_full    = (r_ptr == c_DEPTH);
    assign w_tos_ptr = r_ptr - c_ONE;
    assign w_nos_ptr = r_ptr - (c_AW + 1)'(2);
    assign o_tos     = (r_ptr >= c_ONE)          ? r_mem[w_tos_ptr[c_AW-1:0]] : '0;
    assign o_nos     = (r_ptr >= (c_AW + 1)'(2)) ? r_mem[w_nos_ptr[c_AW-1:0]] : '0;

    // Pop adjusts the pointer first; push then writes at the adjusted pointer.
    // push+pop on an empty stack behaves as a plain push in both builds.
    always_comb begin
        w_ptr_mid  = r_ptr;
        w_push_eff = i_push;
        w_err_set  = 1'b0;
        if (i_pop && !o_empty) begin
            w_ptr_mid = r_ptr - c_ONE;
        end
`ifdef STACK_EXEC_GUARD_EN
        w_err_set = (i_pop && !i_push && o_empty) || (i_push && !i_pop && o_full);
        if (i_push && !i_pop && o_full) begin
            w_push_eff = 1'b0;
        end
        w_ptr_next = w_push_eff ? (w_ptr_mid + c_ONE) : w_ptr_mid;
`else
        if (i_pop && !i_push && o_empty) begin
            w_ptr_mid = c_DEPTH - c_ONE;
        end
        if (!w_push_eff) begin
            w_ptr_next = w_ptr_mid;
        end else if (w_ptr_mid == c_DEPTH) begin
            w_ptr_next = c_ONE;
        end else begin
            w_ptr_next = w_ptr_mid + c_ONE;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_ptr <= w_ptr_next;
            if (w_push_eff) begin
                r_mem[w_ptr_mid[c_AW-1:0]] <= i_data;
            end
        end
    end

`ifdef STACK_EXEC_GUARD_EN
    logic r_err;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end
    assign o_err = r_err;
`else
    logic w_unused_err;
    assign w_unused_err = w_err_set;
    assign o_err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/stack_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : stack_exec_unit
// Description : Single-cycle datapath: operand select, ALU, register file and
//               operand LIFO, with registered result and zero flag.
//               Optional macro STACK_EXEC_GUARD_EN enables stack guarding.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_exec_unit
    import exec_pkg::*;
#(
    parameter int OPCODE_WIDTH = exec_pkg::OPCODE_WIDTH,
    parameter int VALUE_WIDTH  = exec_pkg::VALUE_WIDTH,
    parameter int NUM_REGS     = 8,
    parameter int STACK_DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OPCODE_WIDTH-1:0] op_code,
    input  logic [VALUE_WIDTH-1:0]  source1,
    input  logic [VALUE_WIDTH-1:0]  source2,
    input  logic [VALUE_WIDTH-1:0]  destination,
    input  logic [1:0]              source1_choice,
    input  logic [1:0]              source2_choice,
    input  logic [1:0]              destination_choice,
    input  logic                    push,
    input  logic                    pop,
    output logic                    zero_flag,
    output logic [VALUE_WIDTH-1:0]  result,
    output logic                    stack_empty,
    output logic                    stack_full,
    output logic                    stack_err
);

    localparam int c_RW = $clog2(NUM_REGS);

    logic [VALUE_WIDTH-1:0] r_regs [NUM_REGS];
    logic [VALUE_WIDTH-1:0] r_result;
    logic                   r_zero;

    logic [VALUE_WIDTH-1:0] w_tos;
    logic [VALUE_WIDTH-1:0] w_nos;
    logic [VALUE_WIDTH-1:0] w_a;
    logic [VALUE_WIDTH-1:0] w_b;
    logic [VALUE_WIDTH-1:0] w_alu;
    logic                   w_alu_valid;
    logic                   w_wb;

    always_comb begin
        case (source1_choice)
            SEL_IMM: w_a = source1;
            SEL_REG: w_a = r_regs[source1[c_RW-1:0]];
            SEL_TOS: w_a = w_tos;
            default: w_a = w_nos;
        endcase
        case (source2_choice)
            SEL_IMM: w_b = source2;
            SEL_REG: w_b = r_regs[source2[c_RW-1:0]];
            SEL_TOS: w_b = w_tos;
            default: w_b = w_nos;
        endcase
    end

    // CMP updates flags/result but never writes back or pushes.
    always_comb begin
        w_alu       = '0;
        w_alu_valid = 1'b1;
        w_wb        = 1'b1;
        case (op_code)
            OPCODE_WIDTH'(OP_ADD): w_alu = w_a + w_b;
            OPCODE_WIDTH'(OP_SUB): w_alu = w_a - w_b;
            OPCODE_WIDTH'(OP_AND): w_alu = w_a & w_b;
            OPCODE_WIDTH'(OP_OR):  w_alu = w_a | w_b;
            OPCODE_WIDTH'(OP_XOR): w_alu = w_a ^ w_b;
            OPCODE_WIDTH'(OP_MOV): w_alu = w_a;
            OPCODE_WIDTH'(OP_CMP): begin
                w_alu = w_a - w_b;
                w_wb  = 1'b0;
            end
            default: begin
                w_alu_valid = 1'b0;
                w_wb        = 1'b0;
            end
        endcase
    end

    lifo_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (VALUE_WIDTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .i_push  (push && w_wb),
        .i_pop   (pop),
        .i_data  (w_alu),
        .o_tos   (w_tos),
        .o_nos   (w_nos),
        .o_empty (stack_empty),
        .o_full  (stack_full),
        .o_err   (stack_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_alu_valid) begin
                r_result <= w_alu;
                r_zero   <= (w_alu == '0);
            end
            if (w_wb && destination_choice == DST_REG) begin
                r_regs[destination[c_RW-1:0]] <= w_alu;
            end
        end
    end

    assign result    = r_result;
    assign zero_flag = r_zero;

    // Only the low index bits of register operands are meaningful.
    logic w_unused_bits;
    assign w_unused_bits = ^{source1, source2, destination};

endmodule
`default_nettype wire
